// File: rtl/hex_counter_pkg.sv
// Shared types and helpers for the hex digit counter: debounce states,
// digit width and the digit update rule.
package hex_counter_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] digit;
        logic               wrap;
    } digit_upd_t;

    localparam logic [DIGIT_W-1:0] DIGIT_ZERO = {DIGIT_W{1'b0}};
    localparam logic [DIGIT_W-1:0] DIGIT_MAX  = {DIGIT_W{1'b1}};
    localparam logic [DIGIT_W-1:0] DIGIT_ONE  = DIGIT_W'(1);

    // Load wins over steps; simultaneous up and down cancel each other.
    function automatic digit_upd_t digit_step(
        input logic [DIGIT_W-1:0] cur,
        input logic               load,
        input logic [DIGIT_W-1:0] load_val,
        input logic               up,
        input logic               down
    );
        digit_upd_t res;
        res.digit = cur;
        res.wrap  = 1'b0;
        if (load) begin
            res.digit = load_val;
            res.wrap  = 1'b0;
        end else if (up && !down) begin
            res.digit = cur + DIGIT_ONE;
            res.wrap  = (cur == DIGIT_MAX);
        end else if (down && !up) begin
            res.digit = cur - DIGIT_ONE;
            res.wrap  = (cur == DIGIT_ZERO);
        end else begin
            res.digit = cur;
            res.wrap  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/hex_digit_counter_if.sv
// Button, load and display signals of the hex digit counter.
interface hex_digit_counter_if;
    import hex_counter_pkg::*;

    logic               btn_up;
    logic               btn_down;
    logic               load;
    logic [DIGIT_W-1:0] load_val;
    logic               x0;
    logic               x1;
    logic               x2;
    logic               x3;
    logic               wrap;

    modport master (
        output btn_up, btn_down, load, load_val,
        input  x0, x1, x2, x3, wrap
    );

    modport slave (
        input  btn_up, btn_down, load, load_val,
        output x0, x1, x2, x3, wrap
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce FSM for one raw push-button; emits a
// single-cycle step when a press has been stable long enough.
module btn_debounce
    import hex_counter_pkg::*;
#(
    parameter int DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic step
);

    localparam int              CNT_W    = $clog2(DB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_PW   = PRESS_WAIT;
    localparam logic [1:0] ST_HELD = HELD;
    localparam logic [1:0] ST_RW   = RELEASE_WAIT;

    logic [1:0]       sync_r;
    logic             sync_s;
    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             step_s;

    // Bring the raw button into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], btn};
        end
    end

    assign sync_s    = sync_r[1];
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

    // Debounce next-state and step decode
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        step_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sync_s) begin
                    state_s = ST_PW;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PW: begin
                if (!sync_s) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_HELD;
                    step_s  = 1'b1;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_HELD: begin
                if (!sync_s) begin
                    state_s = ST_RW;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_HELD;
                end
            end
            ST_RW: begin
                if (sync_s) begin
                    state_s = ST_HELD;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Debounce state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    assign step = step_s;

endmodule

// File: rtl/hex_digit_counter.sv
// Single hex digit driven by debounced up/down buttons and a load strobe;
// x3..x0 feed a 7-segment decoder, wrap flags a 15<->0 roll-over.
module hex_digit_counter
    import hex_counter_pkg::*;
#(
    parameter int DB_CYCLES = 250000
) (
    input  logic                clk,
    input  logic                rst_n,
    hex_digit_counter_if.slave  bus
);

    logic [1:0]         rst_sync_r;
    logic               rst_sync_n_s;
    logic               step_up_s;
    logic               step_down_s;
    logic [DIGIT_W-1:0] digit_r;
    logic               wrap_r;
    digit_upd_t         upd_s;

    // Assert reset at once, release it only on a clk edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_sync_n_s = rst_sync_r[1];

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk   (clk),
        .rst_n (rst_sync_n_s),
        .btn   (bus.btn_up),
        .step  (step_up_s)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
        .clk   (clk),
        .rst_n (rst_sync_n_s),
        .btn   (bus.btn_down),
        .step  (step_down_s)
    );

    assign upd_s = digit_step(digit_r, bus.load, bus.load_val, step_up_s, step_down_s);

    // Digit and wrap registers
    always_ff @(posedge clk or negedge rst_sync_n_s) begin
        if (!rst_sync_n_s) begin
            digit_r <= DIGIT_ZERO;
            wrap_r  <= 1'b0;
        end else begin
            digit_r <= upd_s.digit;
            wrap_r  <= upd_s.wrap;
        end
    end

    assign bus.x0   = digit_r[0];
    assign bus.x1   = digit_r[1];
    assign bus.x2   = digit_r[2];
    assign bus.x3   = digit_r[3];
    assign bus.wrap = wrap_r;

endmodule

// File: doc/hex_digit_counter.md
HEX_DIGIT_COUNTER -- requirements
Module: hex_digit_counter

Interface
REQ-001 Parameter DB_CYCLES, default 250000, SHALL set the number of consecutive stable clk samples that qualify a button level change (5 ms at 50 MHz); benches override it to 4.
REQ-002 clk  input  1  single system clock; all state SHALL be updated on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 btn_up  input  1  raw push-button for increment, asynchronous to clk, bouncy, active-high.
REQ-005 btn_down  input  1  raw push-button for decrement, same properties as btn_up.
REQ-006 load  input  1  synchronous load strobe, active-high.
REQ-007 load_val  input  4  value captured on load.
REQ-008 x0, x1, x2, x3  output  1 each  current digit bits, LSB to MSB, registered; they drive the 7-segment decoder inputs directly.
REQ-009 wrap  output  1  one-cycle pulse on 15->0 or 0->15 transitions.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each synchronized button SHALL have its own debounce FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-012 IDLE: on sync=1 -> PRESS_WAIT, counter cleared.
REQ-013 PRESS_WAIT: counter increments while sync=1; on sync=0 -> IDLE; on counter reaching DB_CYCLES-1 -> HELD.
REQ-014 HELD: on sync=0 -> RELEASE_WAIT, counter cleared.
REQ-015 RELEASE_WAIT: counter increments while sync=0; on sync=1 -> HELD; on counter reaching DB_CYCLES-1 -> IDLE.
REQ-016 The debounce counter SHALL be $clog2(DB_CYCLES)+1 bits wide and SHALL saturate, never wrap.
REQ-017 Each button SHALL produce one single-cycle step pulse on the PRESS_WAIT->HELD transition only; holding a button SHALL NOT auto-repeat.
REQ-018 Priority per cycle SHALL be: load, then steps.
  - load=1: digit <= load_val, wrap=0, both step pulses ignored.
  - Up and down step pulses in the same cycle: digit unchanged, wrap=0.
  - Up step alone: digit+1 mod 16.
  - Down step alone: digit-1 mod 16.
REQ-019 Arithmetic SHALL be 4-bit modulo-16; 15+1 = 0 and 0-1 = 15, each asserting wrap in the same cycle the digit updates.
REQ-020 Latency from a raw edge stable for DB_CYCLES to the x3..x0 update SHALL be exactly 2 (sync) + DB_CYCLES + 1 clk cycles.
REQ-021 Bounce shorter than DB_CYCLES on press or release SHALL produce no step.

Reset
REQ-022 rst_n=0 SHALL immediately force:
  - x3..x0 = 0000
  - wrap = 0
  - both FSMs = IDLE
  - both debounce counters = 0
  - synchronizer flops = 0
REQ-023 Reset asserted mid-debounce SHALL discard the pending press; after rst_n deasserts with the button still held, a fresh full DB_CYCLES qualification SHALL be required before a step.
REQ-024 Reset deassertion SHALL be used synchronized to clk (2-flop reset synchronizer inside the block).

Structure
REQ-025 A shared package hex_counter_pkg SHALL hold the debounce state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and the DIGIT_W=4 constant.
REQ-026 Synchronizer plus debounce FSM SHALL be one sub-module, btn_debounce, instantiated twice; the top holds only the digit register, step arbitration and wrap logic.

Verification (DB_CYCLES=4)
REQ-027 After reset, press btn_up clean for 10 cycles, then release for 10 -> digit 0001 exactly 7 cycles after the press edge, one step only, wrap=0.
REQ-028 btn_up toggling every 2 cycles for 20 cycles, then settling low -> digit unchanged at 0000.
REQ-029 load=1 with load_val=1111, then one clean btn_up press -> digit 0000, wrap pulses high for exactly 1 cycle; a following btn_down press -> 1111 with wrap pulsing again.
REQ-030 Both buttons pressed on the same edge with digit 0101 -> digit stays 0101; load=1 with load_val=1010 in the cycle a step fires -> digit 1010.
REQ-031 rst_n pulsed low while btn_up is in PRESS_WAIT, button kept held -> digit 0000 and no step until 4 stable cycles after rst_n release.
REQ-032 Press btn_down from reset 16 times -> digit sequence 1111, 1110, ... 0000, with wrap asserted only on the first press.
